fe_frame_parser: RTL and testbench

Parametrised front-end frame parser for the UART byte stream. Takes strobed bytes from the UART receiver and decodes a header of one command byte, CNT_BYTES big-endian length bytes and an optional XOR checksum byte. It then forwards exactly that many payload bytes to the FIFO side. Adds checksum checking, an inter-byte timeout, a payload down-counter and a downstream abort path.

---
 rtl/fe_frame_parser_if.sv | 26 ++
 rtl/fe_frame_parser.sv | 104 ++++++++++
 tb/tb_fe_frame_parser.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_frame_parser_if.sv
// fe_frame_parser_if: byte-stream input and decoded frame outputs of the UART front-end parser.
interface fe_frame_parser_if #(
  parameter int CNT_W = 16
);
  logic             rok;
  logic [7:0]       mosi;
  logic             fifo_done;
  logic [7:0]       cmd;
  logic [CNT_W-1:0] rx_cnt;
  logic             hdr_valid;
  logic             pay_vld;
  logic [7:0]       pay_data;
  logic [CNT_W-1:0] remain;
  logic             busy;
  logic             frame_done;
  logic             err_chk;
  logic             err_tmo;
  modport master (
    output rok, mosi, fifo_done,
    input  cmd, rx_cnt, hdr_valid, pay_vld, pay_data, remain, busy, frame_done, err_chk, err_tmo
  );
  modport slave (
    input  rok, mosi, fifo_done,
    output cmd, rx_cnt, hdr_valid, pay_vld, pay_data, remain, busy, frame_done, err_chk, err_tmo
  );
endinterface

// File: rtl/fe_frame_parser.sv
// fe_frame_parser: decodes command/length/checksum header from UART bytes and forwards the payload.
module fe_frame_parser #(
  parameter int CNT_BYTES = 2,
  parameter bit CHK_EN    = 1'b1,
  parameter int TMO_CYC   = 100000,
  parameter int TMO_W     = 17
) (
  input logic              clk,
  input logic              rst,
  fe_frame_parser_if.slave bus
);
  localparam int CNT_W = 8 * CNT_BYTES;
  typedef enum logic [1:0] {IDLE, LEN, CHK, PAY} state_t;
  state_t           state;
  logic [1:0]       idx;
  logic [7:0]       xsum;
  logic [TMO_W-1:0] tmo;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] acc_len;
  logic             accept;
  logic             tmo_hit;
  assign cnt_nx  = CNT_W'({bus.rx_cnt, bus.mosi});
  // Without a checksum byte the header completes on the last length byte, before rx_cnt is updated.
  assign accept  = bus.rok && ((state == LEN && idx == 2'(CNT_BYTES - 1) && !CHK_EN) ||
                               (state == CHK && bus.mosi == xsum));
  assign acc_len = state == CHK ? bus.rx_cnt : cnt_nx;
  assign tmo_hit = TMO_CYC != 0 && state != IDLE && tmo == TMO_W'(TMO_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      xsum           <= '0;
      tmo            <= '0;
      bus.cmd        <= '0;
      bus.rx_cnt     <= '0;
      bus.remain     <= '0;
      bus.pay_data   <= '0;
      bus.hdr_valid  <= 1'b0;
      bus.pay_vld    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_chk    <= 1'b0;
      bus.err_tmo    <= 1'b0;
    end else begin
      bus.hdr_valid  <= 1'b0;
      bus.pay_vld    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_chk    <= 1'b0;
      bus.err_tmo    <= 1'b0;
      tmo <= (bus.rok || state == IDLE || TMO_CYC == 0) ? '0 : tmo + TMO_W'(1);
      if (bus.fifo_done) begin
        state      <= IDLE;
        idx        <= '0;
        bus.busy   <= 1'b0;
        bus.remain <= '0;
      end else if (bus.rok) begin
        case (state)
          IDLE: begin
            bus.cmd    <= bus.mosi;
            bus.rx_cnt <= '0;
            idx        <= '0;
            xsum       <= bus.mosi;
            state      <= LEN;
          end
          LEN: begin
            bus.rx_cnt <= cnt_nx;
            xsum       <= xsum ^ bus.mosi;
            idx        <= idx + 2'd1;
            if (idx == 2'(CNT_BYTES - 1)) state <= CHK_EN ? CHK : IDLE;
          end
          CHK:
            if (bus.mosi != xsum) begin
              bus.err_chk <= 1'b1;
              bus.cmd     <= '0;
              bus.rx_cnt  <= '0;
              state       <= IDLE;
            end
          PAY: begin
            bus.pay_vld  <= 1'b1;
            bus.pay_data <= bus.mosi;
            bus.remain   <= bus.remain - CNT_W'(1);
            if (bus.remain == CNT_W'(1)) begin
              bus.frame_done <= 1'b1;
              bus.busy       <= 1'b0;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        if (accept) begin
          bus.hdr_valid  <= 1'b1;
          bus.remain     <= acc_len;
          bus.busy       <= acc_len != '0;
          bus.frame_done <= acc_len == '0;
          state          <= acc_len != '0 ? PAY : IDLE;
        end
      end else if (tmo_hit) begin
        bus.err_tmo <= 1'b1;
        bus.busy    <= 1'b0;
        bus.remain  <= '0;
        state       <= IDLE;
      end
    end
endmodule

// File: tb/tb_fe_frame_parser.sv
// tb_fe_frame_parser: directed and randomized frame checks against a frame-level model.
module tb_fe_frame_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  fe_frame_parser_if #(.CNT_W(16)) a ();
  fe_frame_parser_if #(.CNT_W(32)) b ();
  fe_frame_parser #(.CNT_BYTES(2), .CHK_EN(1'b1), .TMO_CYC(20), .TMO_W(5)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave));
  fe_frame_parser #(.CNT_BYTES(4), .CHK_EN(1'b0), .TMO_CYC(0), .TMO_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave));

  // flags = {hdr_valid, err_chk, err_tmo, pay_vld, frame_done, busy}
  function automatic logic [5:0] flags_a();
    return {a.hdr_valid, a.err_chk, a.err_tmo, a.pay_vld, a.frame_done, a.busy};
  endfunction
  function automatic logic [5:0] flags_b();
    return {b.hdr_valid, b.err_chk, b.err_tmo, b.pay_vld, b.frame_done, b.busy};
  endfunction

  task automatic drv_a(input logic [7:0] d, input logic fd);
    a.rok = 1'b1; a.mosi = d; a.fifo_done = fd;
    @(negedge clk);
    a.rok = 1'b0; a.fifo_done = 1'b0;
  endtask
  task automatic drv_b(input logic [7:0] d);
    b.rok = 1'b1; b.mosi = d;
    @(negedge clk);
    b.rok = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if ({a.cmd, a.rx_cnt, a.remain, a.pay_data, flags_a()} !== '0) begin
      errors++; $display("FAIL reset_a cmd=%h cnt=%h rem=%h data=%h flags=%b exp all 0", a.cmd, a.rx_cnt, a.remain, a.pay_data, flags_a());
    end
    checks++;
    if ({b.cmd, b.rx_cnt, b.remain, b.pay_data, flags_b()} !== '0) begin
      errors++; $display("FAIL reset_b cmd=%h cnt=%h rem=%h data=%h flags=%b exp all 0", b.cmd, b.rx_cnt, b.remain, b.pay_data, flags_b());
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_nominal();
    logic [7:0] p [3];
    p = '{8'h11, 8'h22, 8'h33};
    drv_a(8'hA5, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h03, 1'b0); drv_a(8'hA6, 1'b0);
    checks++;
    if (flags_a() !== 6'b100001 || a.cmd !== 8'hA5 || a.rx_cnt !== 16'h0003 || a.remain !== 16'd3) begin
      errors++; $display("FAIL nominal_hdr flags=%b cmd=%h cnt=%h rem=%0d exp 100001 a5 0003 3", flags_a(), a.cmd, a.rx_cnt, a.remain);
    end
    for (int i = 0; i < 3; i++) begin
      drv_a(p[i], 1'b0);
      checks++;
      if (flags_a() !== (i == 2 ? 6'b000110 : 6'b000101) || a.pay_data !== p[i] || a.remain !== 16'(2 - i)) begin
        errors++; $display("FAIL nominal_pay%0d flags=%b data=%h rem=%0d exp data %h rem %0d", i, flags_a(), a.pay_data, a.remain, p[i], 2 - i);
      end
      idle(1);
      checks++;
      if (flags_a() !== (i == 2 ? 6'b000000 : 6'b000001)) begin
        errors++; $display("FAIL nominal_gap%0d flags=%b busy exp %0d", i, flags_a(), i != 2);
      end
    end
  endtask

  task automatic test_bad_chk();
    drv_a(8'hA5, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h03, 1'b0); drv_a(8'h00, 1'b0);
    checks++;
    if (flags_a() !== 6'b010000 || a.cmd !== 8'h00 || a.rx_cnt !== 16'h0000) begin
      errors++; $display("FAIL bad_chk flags=%b cmd=%h cnt=%h exp 010000 00 0000", flags_a(), a.cmd, a.rx_cnt);
    end
    drv_a(8'h5A, 1'b0);
    checks++;
    if (a.cmd !== 8'h5A || flags_a() !== 6'b0) begin
      errors++; $display("FAIL bad_chk_next cmd=%h flags=%b exp 5a 000000", a.cmd, flags_a());
    end
    drv_a(8'h00, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h5A, 1'b0);
    checks++;
    if (flags_a() !== 6'b100010) begin
      errors++; $display("FAIL bad_chk_recover flags=%b exp 100010", flags_a());
    end
  endtask

  task automatic test_zero_len();
    drv_a(8'h10, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h10, 1'b0);
    checks++;
    if (flags_a() !== 6'b100010 || a.remain !== 16'd0 || a.cmd !== 8'h10) begin
      errors++; $display("FAIL zero_len flags=%b rem=%0d cmd=%h exp 100010 0 10", flags_a(), a.remain, a.cmd);
    end
    idle(1);
    checks++;
    if (flags_a() !== 6'b0) begin
      errors++; $display("FAIL zero_len_after flags=%b exp 000000", flags_a());
    end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    drv_a(8'h77, 1'b0); drv_a(8'h00, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20 && a.err_tmo !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL timeout_early err_tmo rose before 20 clocks, exp 0");
    end
    checks++;
    if (flags_a() !== 6'b001000 || a.remain !== 16'd0) begin
      errors++; $display("FAIL timeout_pulse flags=%b rem=%0d exp 001000 0", flags_a(), a.remain);
    end
    drv_a(8'h33, 1'b0);
    checks++;
    if (a.cmd !== 8'h33 || flags_a() !== 6'b0) begin
      errors++; $display("FAIL timeout_next cmd=%h flags=%b exp 33 000000", a.cmd, flags_a());
    end
    drv_a(8'h00, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h33, 1'b0);
  endtask

  task automatic test_abort();
    drv_a(8'hA5, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h03, 1'b0); drv_a(8'hA6, 1'b0);
    drv_a(8'h11, 1'b0);
    drv_a(8'h22, 1'b1);
    checks++;
    if (flags_a() !== 6'b0 || a.remain !== 16'd0 || a.pay_data !== 8'h11) begin
      errors++; $display("FAIL abort flags=%b rem=%0d data=%h exp 000000 0 11", flags_a(), a.remain, a.pay_data);
    end
    idle(1);
    drv_a(8'h42, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h42, 1'b0);
    checks++;
    if (flags_a() !== 6'b100010 || a.cmd !== 8'h42) begin
      errors++; $display("FAIL abort_recover flags=%b cmd=%h exp 100010 42", flags_a(), a.cmd);
    end
  endtask

  task automatic test_back_to_back();
    drv_a(8'h3C, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h01, 1'b0); drv_a(8'h3D, 1'b0);
    drv_a(8'h99, 1'b0);
    checks++;
    if (flags_a() !== 6'b000110 || a.pay_data !== 8'h99) begin
      errors++; $display("FAIL b2b_last flags=%b data=%h exp 000110 99", flags_a(), a.pay_data);
    end
    drv_a(8'h10, 1'b0);
    checks++;
    if (a.cmd !== 8'h10 || flags_a() !== 6'b0) begin
      errors++; $display("FAIL b2b_cmd cmd=%h flags=%b exp 10 000000", a.cmd, flags_a());
    end
    drv_a(8'h00, 1'b0); drv_a(8'h00, 1'b0); drv_a(8'h10, 1'b0);
    checks++;
    if (flags_a() !== 6'b100010) begin
      errors++; $display("FAIL b2b_zero flags=%b exp 100010", flags_a());
    end
  endtask

  // Frame-level model: header bytes, xor checksum, then len payload bytes with a shrinking count.
  task automatic test_random();
    logic [7:0] h [4];
    logic [7:0] c, x, d;
    logic [5:0] exp_f;
    logic       bad, bsy;
    int         len, g;
    for (int f = 0; f < 40; f++) begin
      c   = 8'($urandom);
      len = $urandom_range(0, 5);
      bad = $urandom_range(0, 3) == 0;
      x   = c ^ 8'(len >> 8) ^ 8'(len);
      h   = '{c, 8'(len >> 8), 8'(len), bad ? x ^ 8'($urandom_range(1, 255)) : x};
      bsy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        drv_a(h[k], 1'b0);
        exp_f = k < 3 ? 6'b0 : bad ? 6'b010000 : len == 0 ? 6'b100010 : 6'b100001;
        checks++;
        if (flags_a() !== exp_f || (k == 3 && a.cmd !== (bad ? 8'h00 : c)) || (k == 3 && !bad && a.rx_cnt !== 16'(len))) begin
          errors++; $display("FAIL rand_hdr f%0d k%0d flags=%b cmd=%h cnt=%h exp %b %h %h", f, k, flags_a(), a.cmd, a.rx_cnt, exp_f, bad ? 8'h00 : c, 16'(len));
        end
        bsy = k == 3 && !bad && len != 0;
        g = $urandom_range(0, 2);
        idle(g);
        if (g > 0) begin
          checks++;
          if (flags_a() !== {5'b0, bsy}) begin
            errors++; $display("FAIL rand_gap f%0d flags=%b exp %b", f, flags_a(), {5'b0, bsy});
          end
        end
      end
      for (int i = 0; i < len && !bad; i++) begin
        d = 8'($urandom);
        drv_a(d, 1'b0);
        exp_f = i == len - 1 ? 6'b000110 : 6'b000101;
        checks++;
        if (flags_a() !== exp_f || a.pay_data !== d || a.remain !== 16'(len - 1 - i)) begin
          errors++; $display("FAIL rand_pay f%0d i%0d flags=%b data=%h rem=%0d exp %b %h %0d", f, i, flags_a(), a.pay_data, a.remain, exp_f, d, len - 1 - i);
        end
        idle($urandom_range(0, 2));
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] h [5];
    h = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02};
    for (int k = 0; k < 4; k++) drv_b(h[k]);
    checks++;
    if (flags_b() !== 6'b0) begin
      errors++; $display("FAIL sweep_pre flags=%b exp 000000", flags_b());
    end
    drv_b(h[4]);
    checks++;
    if (flags_b() !== 6'b100001 || b.cmd !== 8'h01 || b.rx_cnt !== 32'h00000102 || b.remain !== 32'h102) begin
      errors++; $display("FAIL sweep_hdr flags=%b cmd=%h cnt=%h rem=%h exp 100001 01 00000102 102", flags_b(), b.cmd, b.rx_cnt, b.remain);
    end
    idle(40);
    checks++;
    if (flags_b() !== 6'b000001) begin
      errors++; $display("FAIL sweep_no_tmo flags=%b exp 000001", flags_b());
    end
    drv_b(8'hC3);
    checks++;
    if (flags_b() !== 6'b000101 || b.pay_data !== 8'hC3 || b.remain !== 32'h101) begin
      errors++; $display("FAIL sweep_pay flags=%b data=%h rem=%h exp 000101 c3 101", flags_b(), b.pay_data, b.remain);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({b.cmd, b.rx_cnt, b.remain, b.pay_data, flags_b()} !== '0 || {a.cmd, a.rx_cnt} !== '0) begin
      errors++; $display("FAIL async_rst b: cmd=%h cnt=%h rem=%h data=%h flags=%b a: cmd=%h exp all 0", b.cmd, b.rx_cnt, b.remain, b.pay_data, flags_b(), a.cmd);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    a.rok = 1'b0; a.mosi = '0; a.fifo_done = 1'b0;
    b.rok = 1'b0; b.mosi = '0; b.fifo_done = 1'b0;
    test_reset();
    test_nominal();
    test_bad_chk();
    test_zero_len();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
